// File: rtl/button_events.sv
// rtl/button_events.sv - press/release/click/double-click/long-press event detector for one button.
// Optional autorepeat while in LONG: define BUTTON_EVENTS_AUTOREPEAT_EN.
module button_events #(
    parameter int CNT_W        = 24,
    parameter int LONG_TICKS   = 12_500_000,
    parameter int DCLICK_TICKS = 3_750_000,
    parameter int REPEAT_TICKS = 2_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_LONG,
        S_WAIT,
        S_PRESS2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_prev_q, btn_prev_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             single_q, single_d;
    logic             dbl_pend_q, dbl_pend_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             rise, fall;

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    logic repeat_q, repeat_d;
`endif

    always_comb begin
        rise       = btn_in & ~btn_prev_q;
        fall       = ~btn_in & btn_prev_q;
        btn_prev_d = btn_in;
        press_d    = rise;
        release_d  = fall;
        state_d    = state_q;
        cnt_d      = cnt_q;
        single_d   = 1'b0;
        dbl_pend_d = 1'b0;
        long_d     = 1'b0;
        // The double click is reported one cycle after the second press_pulse.
        double_d   = dbl_pend_q;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
        repeat_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS;
                    cnt_d   = '0;
                end
            end
            S_PRESS: begin
                if (fall) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_d = S_IDLE;
                end else begin
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
                    // The main counter doubles as the repeat counter here.
                    if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`endif
                end
            end
            S_WAIT: begin
                // Timeout wins over a coincident rise; that rise starts a fresh press.
                if (cnt_q == DCLICK_LAST) begin
                    single_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = rise ? S_PRESS : S_IDLE;
                end else if (rise) begin
                    state_d    = S_PRESS2;
                    dbl_pend_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            btn_prev_q <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            single_q   <= 1'b0;
            dbl_pend_q <= 1'b0;
            double_q   <= 1'b0;
            long_q     <= 1'b0;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
            repeat_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_prev_d;
            press_q    <= press_d;
            release_q  <= release_d;
            single_q   <= single_d;
            dbl_pend_q <= dbl_pend_d;
            double_q   <= double_d;
            long_q     <= long_d;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
            repeat_q   <= repeat_d;
`endif
        end
    end

    assign held          = btn_prev_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign single_click  = single_q;
    assign double_click  = double_q;
    assign long_press    = long_q;

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    assign repeat_pulse = repeat_q;
`else
    logic unused_repeat_ticks;
    assign unused_repeat_ticks = ^REPEAT_TICKS;
    assign repeat_pulse        = 1'b0;
`endif

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - randomized bench for button_events against a press-list reference model.
module tb_button_events;

    localparam int L = 10;
    localparam int D = 6;
    localparam int R = 4;
    localparam int N = 3000;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic held, press_pulse, release_pulse, single_click, double_click, long_press, repeat_pulse;

    bit btn_a [N];
    bit rst_a [N];
    bit ex_held [N];
    bit ex_press [N];
    bit ex_release [N];
    bit ex_single [N];
    bit ex_double [N];
    bit ex_long [N];
    bit ex_repeat [N];

    int gi = 0;
    int n_checks = 0;
    int n_errors = 0;

    button_events #(
        .CNT_W(8),
        .LONG_TICKS(L),
        .DCLICK_TICKS(D),
        .REPEAT_TICKS(R)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_in(btn_in),
        .held(held),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .single_click(single_click),
        .double_click(double_click),
        .long_press(long_press),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic seg(input bit b, input bit r, input int len);
        for (int i = 0; i < len; i++) begin
            if (gi < N) begin
                btn_a[gi] = b;
                rst_a[gi] = r;
                gi++;
            end
        end
    endtask

    function automatic bit prev_of(input int e);
        if (e == 0) return 1'b0;
        if (rst_a[e-1]) return 1'b0;
        return btn_a[e-1];
    endfunction

    // Expected outputs indexed by the clock edge after which they are visible.
    task automatic build_model();
        int pr_r[$];
        int pr_f[$];
        int pr_k[$];
        int k, r, f, t, x, r2;
        bit second;
        for (int e = 0; e < N; e++) begin
            bit p;
            p = prev_of(e);
            ex_held[e]    = !rst_a[e] && btn_a[e];
            ex_press[e]   = !rst_a[e] && btn_a[e] && !p;
            ex_release[e] = !rst_a[e] && !btn_a[e] && p;
        end
        for (int e = 0; e < N; e++) begin
            if (ex_press[e]) begin
                k = e + 1;
                while (k < N && !rst_a[k] && btn_a[k]) k++;
                pr_r.push_back(e);
                pr_f.push_back(k);
                pr_k.push_back((k >= N) ? 2 : (rst_a[k] ? 1 : 0));
            end
        end
        second = 1'b0;
        for (int i = 0; i < pr_r.size(); i++) begin
            r = pr_r[i];
            f = pr_f[i];
            if (second) begin
                second = 1'b0;
            end else if (f > r + L) begin
                ex_long[r+L] = 1'b1;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
                for (int j = r + L + R; j < f; j += R) ex_repeat[j] = 1'b1;
`endif
            end else if (pr_k[i] == 0) begin
                t = f + D;
                x = f + 1;
                while (x < N && !rst_a[x]) x++;
                r2 = (i + 1 < pr_r.size()) ? pr_r[i+1] : (1 << 30);
                if (r2 < t && r2 < x) begin
                    if (r2 + 1 < N && !rst_a[r2+1]) ex_double[r2+1] = 1'b1;
                    second = 1'b1;
                end else if (t < x && t < N) begin
                    ex_single[t] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int kind;
        reset  = 1'b1;
        btn_in = 1'b0;

        seg(0, 1, 3);
        seg(0, 0, 5);
        seg(1, 0, 3);  seg(0, 0, 12);
        seg(1, 0, 3);  seg(0, 0, 2);  seg(1, 0, 3);  seg(0, 0, 12);
        seg(1, 0, 20); seg(0, 0, 12);
        seg(1, 0, 3);  seg(0, 0, D);  seg(1, 0, 12); seg(0, 0, 12);
        seg(1, 0, 3);  seg(0, 0, 2);  seg(0, 1, 1);  seg(0, 0, 12);
        seg(1, 0, 4);  seg(1, 1, 1);  seg(1, 0, 3);  seg(0, 0, 12);
        seg(1, 0, 3);  seg(0, 0, D-1); seg(1, 0, 15); seg(0, 0, 12);
        while (gi < N - 30) begin
            kind = $urandom_range(0, 11);
            if (kind == 0) begin
                seg(1'($urandom_range(0, 1)), 1, $urandom_range(1, 2));
            end else begin
                seg(1, 0, ($urandom_range(0, 2) == 0) ? $urandom_range(9, 26) : $urandom_range(1, 5));
                seg(0, 0, $urandom_range(1, 9));
            end
        end

        build_model();

        for (int e = 0; e < N; e++) begin
            @(negedge clk);
            reset  = rst_a[e];
            btn_in = btn_a[e];
            @(posedge clk);
            #1;
            chk($sformatf("held@%0d", e), 32'(held), 32'(ex_held[e]));
            chk($sformatf("press@%0d", e), 32'(press_pulse), 32'(ex_press[e]));
            chk($sformatf("release@%0d", e), 32'(release_pulse), 32'(ex_release[e]));
            chk($sformatf("single@%0d", e), 32'(single_click), 32'(ex_single[e]));
            chk($sformatf("double@%0d", e), 32'(double_click), 32'(ex_double[e]));
            chk($sformatf("long@%0d", e), 32'(long_press), 32'(ex_long[e]));
            chk($sformatf("repeat@%0d", e), 32'(repeat_pulse), 32'(ex_repeat[e]));
            chk($sformatf("exclusive@%0d", e),
                32'((32'(single_click) + 32'(double_click) + 32'(long_press)) <= 1), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
